// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline sequencing unit: load-use stalls, branch flushes, memory freeze
//
// Ports:
//   clk, reset                  core clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_uses_*    source registers of the ID instruction and whether they are read
//   ex_mem_read, ex_rd          load indication and destination register of the EX instruction
//   ex_branch_taken             taken branch / JALR resolved in EX this cycle
//   mem_busy                    data memory wait state; the whole pipeline is frozen
//   counter_clr                 synchronous clear of both performance counters
//   *_enable, *_flush           pipeline register load enables and bubble inserts
//   state_o                     current sequencing state (RUN=0, STALL=1, FLUSH=2)
//   stall_cycles, flush_events  saturating performance counters
module hazard_controller #(
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             counter_clr,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    state_next    = state;
    cnt_next      = cnt;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    if (mem_busy) begin
      // Freeze: nothing moves and the running sequence keeps its remaining count.
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      stall_inc     = 1'b1;
    end else if (ex_branch_taken) begin
      // A redirect wins over any stall or flush in progress and restarts the flush.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc   = 1'b1;
      if (FLUSH_LEN > 1) begin
        state_next = FLUSH;
        cnt_next   = 4'(FLUSH_LEN - 1);
      end else begin
        state_next = RUN;
        cnt_next   = 4'd0;
      end
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
            stall_inc    = 1'b1;
            if (LOAD_LAT > 1) begin
              state_next = STALL;
              cnt_next   = 4'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
          stall_inc    = 1'b1;
          cnt_next     = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_next = RUN;
          end
        end
        FLUSH: begin
          if_id_flush = 1'b1;
          cnt_next    = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 4'd0;
        end
      endcase
    end

    // While reset is held every control is forced low, independent of the clock.
    if (!reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (counter_clr) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_inc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_inc && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule
